// File: rtl/victim_wb_buffer.sv
// Victim write-back buffer: a coalescing write FIFO drained to memory one word at a time,
// with combinational byte-wise forwarding for refill probes.
module victim_wb_buffer #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned AW    = 19,
    parameter  int unsigned DW    = 16,
    localparam int unsigned BW    = DW / 8,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] vwb_addr,
    input  logic [DW-1:0] vwb_data_out,
    input  logic [BW-1:0] vwb_bytesel,
    input  logic          vwb_access,
    input  logic          vwb_wr_en,
    output logic          vwb_ack,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_data_out,
    output logic [BW-1:0] m_bytesel,
    output logic          m_access,
    output logic          m_wr_en,
    input  logic          m_ack,
    input  logic [AW-1:0] probe_addr,
    output logic          probe_hit,
    output logic [DW-1:0] probe_data,
    output logic [BW-1:0] probe_bytesel,
    input  logic          flush,
    output logic          flush_done,
    output logic [PW:0]   level,
    output logic          full,
    output logic          empty
);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [BW-1:0]    be_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q, tail_q, young_idx;
    logic [PW:0]      count_q;
    logic             vwb_ack_q;
    state_e           state_q, state_d;
    logic             accept, head_busy, merge, push, pop;

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign level     = count_q;
    assign vwb_ack   = vwb_ack_q;
    assign young_idx = tail_q - PW'(1);

    // The entry being issued must stay stable, so it cannot absorb a coalescing write.
    assign head_busy = (state_q == StIssue) && (young_idx == head_q);
    assign accept    = vwb_access && vwb_wr_en && !full && !vwb_ack_q;
    assign merge     = accept && !empty && (addr_q[young_idx] == vwb_addr) && !head_busy;
    assign push      = accept && !merge;
    assign pop       = (state_q == StIssue) && m_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            vwb_ack_q <= 1'b0;
        end else begin
            vwb_ack_q <= accept;
            count_q   <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            if (push) begin
                tail_q          <= tail_q + PW'(1);
                valid_q[tail_q] <= 1'b1;
            end
            if (pop) begin
                head_q          <= head_q + PW'(1);
                valid_q[head_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= vwb_addr;
            data_q[tail_q] <= vwb_data_out;
            be_q[tail_q]   <= vwb_bytesel;
        end else if (merge) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (vwb_bytesel[b]) data_q[young_idx][b*8 +: 8] <= vwb_data_out[b*8 +: 8];
            end
            be_q[young_idx] <= be_q[young_idx] | vwb_bytesel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty) state_d = StIssue;
            StIssue: if (m_ack)  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_access   = 1'b0;
        m_addr     = '0;
        m_data_out = '0;
        m_bytesel  = '0;
        if (state_q == StIssue) begin
            m_access   = 1'b1;
            m_addr     = addr_q[head_q];
            m_data_out = data_q[head_q];
            m_bytesel  = be_q[head_q];
        end
    end

    assign m_wr_en    = m_access;
    assign flush_done = flush && empty && (state_q == StIdle);

    // Walk oldest to newest so younger entries overwrite older bytes.
    always_comb begin : probe_scan
        logic [PW-1:0] idx;
        idx           = head_q;
        probe_data    = '0;
        probe_bytesel = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_q + PW'(k);
            if (valid_q[idx] && (addr_q[idx] == probe_addr)) begin
                for (int b = 0; b < int'(BW); b++) begin
                    if (be_q[idx][b]) begin
                        probe_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
                        probe_bytesel[b]     = 1'b1;
                    end
                end
            end
        end
    end

    assign probe_hit = (probe_bytesel != '0);

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Bench for victim_wb_buffer: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based reference model.
module tb_victim_wb_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 19;
    localparam int unsigned DW    = 16;
    localparam int unsigned BW    = 2;
    localparam int unsigned LW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] vwb_addr;
    logic [DW-1:0] vwb_data_out;
    logic [BW-1:0] vwb_bytesel;
    logic          vwb_access, vwb_wr_en, vwb_ack;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data_out;
    logic [BW-1:0] m_bytesel;
    logic          m_access, m_wr_en, m_ack;
    logic [AW-1:0] probe_addr;
    logic          probe_hit;
    logic [DW-1:0] probe_data;
    logic [BW-1:0] probe_bytesel;
    logic          flush, flush_done, full, empty;
    logic [LW-1:0] level;

    victim_wb_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .vwb_addr(vwb_addr), .vwb_data_out(vwb_data_out), .vwb_bytesel(vwb_bytesel),
        .vwb_access(vwb_access), .vwb_wr_en(vwb_wr_en), .vwb_ack(vwb_ack),
        .m_addr(m_addr), .m_data_out(m_data_out), .m_bytesel(m_bytesel),
        .m_access(m_access), .m_wr_en(m_wr_en), .m_ack(m_ack),
        .probe_addr(probe_addr), .probe_hit(probe_hit), .probe_data(probe_data),
        .probe_bytesel(probe_bytesel), .flush(flush), .flush_done(flush_done),
        .level(level), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } ent_t;

    // Reference model: queued words plus where the drain currently is.
    ent_t q[$];
    ent_t wlog[$];
    bit   issuing, in_gap, ack_pend;
    int   issue_age;
    int   mode;  // 0: m_ack low, 1: ack one cycle after m_access, 2: random
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        issuing   = 0;
        in_gap    = 0;
        ack_pend  = 0;
        issue_age = 0;
    endtask

    function automatic void model_probe(input logic [AW-1:0] pa, output logic [DW-1:0] pd,
                                        output logic [BW-1:0] pb);
        pd = '0;
        pb = '0;
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (q[i].addr == pa) begin
                for (int b = 0; b < int'(BW); b++) begin
                    if (q[i].be[b] && !pb[b]) begin
                        pb[b]         = 1'b1;
                        pd[b*8 +: 8]  = q[i].data[b*8 +: 8];
                    end
                end
            end
        end
    endfunction

    // One clock: drive m_ack, check all outputs at the falling edge, advance the model.
    task automatic tick();
        ent_t          h, e;
        logic [DW-1:0] pd;
        logic [BW-1:0] pb;
        bit            acc, mrg, pop;
        int            pre_size;
        case (mode)
            0:       m_ack = 1'b0;
            1:       m_ack = issuing && (issue_age >= 1);
            default: m_ack = ($urandom_range(0, 2) == 0);
        endcase
        @(negedge clk);
        h = '{addr: '0, data: '0, be: '0};
        if (issuing) h = q[0];
        chk("vwb_ack", vwb_ack, ack_pend);
        chk("m_access", m_access, issuing);
        chk("m_wr_en", m_wr_en, issuing);
        chk("m_addr", m_addr, h.addr);
        chk("m_data_out", m_data_out, h.data);
        chk("m_bytesel", m_bytesel, h.be);
        chk("level", level, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("flush_done", flush_done, flush && q.size() == 0 && !issuing && !in_gap);
        model_probe(probe_addr, pd, pb);
        chk("probe_data", probe_data, pd);
        chk("probe_bytesel", probe_bytesel, pb);
        chk("probe_hit", probe_hit, pb != '0);
        if (m_access && m_ack) wlog.push_back('{addr: m_addr, data: m_data_out, be: m_bytesel});

        pre_size = q.size();
        acc = reset && vwb_access && vwb_wr_en && (pre_size < int'(DEPTH)) && !ack_pend;
        pop = reset && issuing && m_ack;
        mrg = acc && pre_size > 0 && q[pre_size-1].addr == vwb_addr && !(issuing && pre_size == 1);
        e = '{addr: vwb_addr, data: vwb_data_out, be: vwb_bytesel};
        if (mrg) begin
            e = q[pre_size-1];
            for (int b = 0; b < int'(BW); b++)
                if (vwb_bytesel[b]) e.data[b*8 +: 8] = vwb_data_out[b*8 +: 8];
            e.be = e.be | vwb_bytesel;
        end

        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (mrg)      q[pre_size-1] = e;
            else if (acc) q.push_back(e);
            if (pop) void'(q.pop_front());
            ack_pend = acc;
            if (issuing) begin
                if (pop) begin
                    issuing = 0;
                    in_gap  = 1;
                end else begin
                    issue_age++;
                end
            end else if (in_gap) begin
                in_gap = 0;
            end else if (pre_size > 0) begin
                issuing   = 1;
                issue_age = 0;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        bit done = 0;
        vwb_addr     = a;
        vwb_data_out = d;
        vwb_bytesel  = b;
        vwb_wr_en    = 1'b1;
        vwb_access   = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            done = ack_pend;
        end
        vwb_access = 1'b0;
        chk("push_accepted", done, 1);
    endtask

    task automatic drain();
        mode = 1;
        for (int i = 0; i < 200 && (q.size() != 0 || issuing || in_gap); i++) tick();
        chk("drain_empty", empty, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int  nacks, early;
        bit  got, seen;
        reset = 1'b0; vwb_addr = '0; vwb_data_out = '0; vwb_bytesel = '0;
        vwb_access = 1'b0; vwb_wr_en = 1'b0; m_ack = 1'b0; probe_addr = '0; flush = 1'b0;
        mode = 0;
        model_reset();
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_m_access", m_access, 0);
        chk("rst_vwb_ack", vwb_ack, 0);
        chk("rst_m_addr", m_addr, 0);
        run(2);
        reset = 1'b1;

        // Eight sequential words drained in order.
        mode = 1;
        wlog.delete();
        for (int i = 0; i < 8; i++) push(AW'(32'h10 + i), DW'(32'hA000 + i), 2'b11);
        drain();
        chk("seq_count", wlog.size(), 8);
        for (int i = 0; i < 8 && i < int'(wlog.size()); i++) begin
            chk("seq_addr", wlog[i].addr, 32'h10 + i);
            chk("seq_data", wlog[i].data, 32'hA000 + i);
            chk("seq_be", wlog[i].be, 2'b11);
        end

        // Fill to capacity with memory stalled; the ninth word must wait for a pop.
        mode = 0;
        wlog.delete();
        for (int i = 0; i < 8; i++) push(AW'(32'h100 + i), DW'($urandom), 2'b11);
        chk("full_after_8", full, 1);
        vwb_addr = AW'(32'h108); vwb_data_out = 16'h9999; vwb_bytesel = 2'b11;
        vwb_access = 1'b1;
        nacks = 0;
        repeat (5) begin
            tick();
            if (vwb_ack) nacks++;
        end
        chk("full_no_ack", nacks, 0);
        chk("full_flag", full, 1);
        chk("full_level", level, 8);
        mode = 1;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = ack_pend;
        end
        vwb_access = 1'b0;
        chk("ninth_accepted", got, 1);
        chk("ninth_after_first_pop", wlog.size(), 1);
        drain();
        chk("full_drain_count", wlog.size(), 9);

        // Two halves to the same address coalesce behind a different head.
        mode = 0;
        wlog.delete();
        push(AW'(32'h40), 16'h4444, 2'b11);
        run(2);
        push(AW'(32'h20), 16'h00AD, 2'b01);
        push(AW'(32'h20), 16'hDE00, 2'b10);
        chk("coalesce_level", level, 2);
        drain();
        chk("coalesce_writes", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("coalesce_addr", wlog[1].addr, 32'h20);
            chk("coalesce_data", wlog[1].data, 16'hDEAD);
            chk("coalesce_be", wlog[1].be, 2'b11);
        end

        // Issuing head blocks the merge; the probe still combines both entries.
        mode = 0;
        push(AW'(32'h30), 16'h1111, 2'b11);
        run(2);
        push(AW'(32'h30), 16'h2200, 2'b10);
        chk("probe_level", level, 2);
        probe_addr = AW'(32'h30);
        #1;
        chk("probe30_hit", probe_hit, 1);
        chk("probe30_data", probe_data, 16'h2211);
        chk("probe30_be", probe_bytesel, 2'b11);
        probe_addr = AW'(32'h31);
        #1;
        chk("probe31_hit", probe_hit, 0);
        chk("probe31_data", probe_data, 0);
        chk("probe31_be", probe_bytesel, 0);
        drain();

        // Flush completes only after the last write and its gap.
        mode = 0;
        wlog.delete();
        for (int i = 0; i < 3; i++) push(AW'(32'h60 + i), DW'($urandom), 2'b11);
        flush = 1'b1;
        #1;
        chk("flush_low_start", flush_done, 0);
        mode = 1;
        seen  = 0;
        early = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            if (flush_done) seen = 1;
            else if (wlog.size() == 3 && !in_gap && !issuing) early++;
        end
        chk("flush_seen", seen, 1);
        chk("flush_writes", wlog.size(), 3);
        chk("flush_not_late", early, 0);
        flush = 1'b0;

        // Reset mid-issue discards everything and drops m_access at once.
        mode = 0;
        for (int i = 0; i < 5; i++) push(AW'(32'h70 + i), DW'($urandom), 2'b11);
        run(2);
        chk("pre_reset_access", m_access, 1);
        chk("pre_reset_level", level, 5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_access", m_access, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_full", full, 0);
        chk("async_rst_addr", m_addr, 0);
        model_reset();
        run(2);
        reset = 1'b1;
        wlog.delete();
        mode = 1;
        run(20);
        chk("post_reset_no_write", wlog.size(), 0);

        // Random traffic with random (sometimes stray) m_ack pulses.
        mode = 2;
        for (int i = 0; i < 400; i++) begin
            vwb_access   = $urandom_range(0, 1) == 1;
            vwb_wr_en    = $urandom_range(0, 3) != 0;
            vwb_addr     = AW'(32'h50 + $urandom_range(0, 3));
            vwb_data_out = DW'($urandom);
            vwb_bytesel  = BW'($urandom_range(0, 3));
            probe_addr   = AW'(32'h50 + $urandom_range(0, 4));
            flush        = $urandom_range(0, 3) == 0;
            tick();
        end
        vwb_access = 1'b0;
        flush      = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/victim_wb_buffer.md
VICTIM_WB_BUFFER -- requirements
Module: victim_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of word entries; SHALL be a power of 2, minimum 2.
REQ-002 Parameter AW, default 19, word-address width.
REQ-003 Parameter DW, default 16, data width; byte-enable width BW = DW/8.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 vwb_addr  input  AW  word address of victim write.
REQ-007 vwb_data_out  input  DW  victim write data.
REQ-008 vwb_bytesel  input  BW  victim byte enables.
REQ-009 vwb_access  input  1  victim request valid.
REQ-010 vwb_wr_en  input  1  victim request is a write; requests with vwb_wr_en=0 are ignored and never acked.
REQ-011 vwb_ack  output  1  one-cycle accept pulse.
REQ-012 m_addr  output  AW  memory word address.
REQ-013 m_data_out  output  DW  memory write data.
REQ-014 m_bytesel  output  BW  memory byte enables.
REQ-015 m_access  output  1  memory request.
REQ-016 m_wr_en  output  1  equals m_access; the block only writes.
REQ-017 m_ack  input  1  memory completion, one cycle.
REQ-018 probe_addr  input  AW  refill lookup address.
REQ-019 probe_hit / probe_data / probe_bytesel  output  1 / DW / BW  combinational forwarding result.
REQ-020 flush  input  1  drain request; flush_done output 1; level output $clog2(DEPTH)+1; full, empty outputs 1.

Function
REQ-021 Storage: circular FIFO of DEPTH entries {addr, data, be}, head/tail pointers wrap modulo DEPTH, count register drives level.
REQ-022 full = (count == DEPTH); empty = (count == 0); both from registered count only.
REQ-023 Accept when vwb_access && vwb_wr_en && !full && !vwb_ack; vwb_ack asserted exactly the next cycle for one cycle.
REQ-024 Coalesce: if accepted address equals youngest entry address, youngest entry exists, and youngest is not the head in ISSUE, merge enabled bytes into it; count unchanged.
REQ-025 Otherwise push a new entry at tail; count +1.
REQ-026 Drain FSM states IDLE, ISSUE, GAP.
REQ-027 IDLE -> ISSUE when !empty; m_access=1 with head entry driven stable on m_addr/m_data_out/m_bytesel.
REQ-028 ISSUE: hold all memory outputs until m_ack; on m_ack pop head, count -1, go GAP.
REQ-029 GAP: m_access=0 for exactly one cycle, then IDLE.
REQ-030 Push and pop in same cycle: count unchanged; full evaluated before the pop, so a push while full is refused even if a pop occurs.
REQ-031 Probe: scan all valid entries, newest to oldest; per byte, take the newest entry enabling that byte; probe_bytesel = OR of matched enables, probe_hit = (probe_bytesel != 0), unmatched data bytes = 0.
REQ-032 Flush: flush_done asserted combinationally while flush is high and empty and FSM in IDLE; flush does not block accepts.
REQ-033 m_ack outside ISSUE is ignored.

Reset
REQ-034 While reset low: pointers, count, FSM=IDLE, vwb_ack=0, m_access=0, m_wr_en=0, m_addr/m_data_out/m_bytesel=0, all entry valid bits cleared; empty=1, full=0, level=0.
REQ-035 Reset asserted mid-ISSUE drops m_access immediately (asynchronous); pending entries are discarded.

Verification
REQ-036 Push 8 words addr 0x00010..0x00017 data 0xA000+i, be=11, m_ack 1 cycle after m_access -> memory receives 8 writes in order, each separated by one GAP cycle; empty=1 after last.
REQ-037 DEPTH=8, m_ack held low, push 9 distinct words -> 8 acks, ninth vwb_access held without ack, full=1, level=8; release m_ack -> ninth accepted after first pop.
REQ-038 Push 0x00020 data 0x00AD be=01, then 0x00020 data 0xDE00 be=10 while head is another address -> level +1 only; memory receives 0xDEAD be=11 at 0x00020.
REQ-039 Entries 0x00030=0x1111 be=11 then 0x00030=0x2200 be=10 (head in ISSUE blocks merge) -> probe 0x00030 returns hit=1, data 0x2211, bytesel=11; probe 0x00031 returns hit=0.
REQ-040 Assert reset low while m_access=1 with level=5 -> m_access=0 same time step, level=0, empty=1; after release no memory write occurs.
REQ-041 flush high with 3 entries queued -> flush_done=0 until third m_ack plus GAP cycle, then flush_done=1.
